// File: rtl/posit_pkg.sv
// Shared posit definitions: default word geometry, special encodings and the
// unpacked-operand record used by the decode datapath.
package posit_pkg;

    localparam int unsigned POSIT_BITS = 32;
    localparam int unsigned POSIT_ES   = 3;

    typedef struct packed {
        logic                  sign;
        logic                  zero;
        logic                  nar;
        logic [POSIT_BITS-1:0] seed;
        logic [POSIT_ES-1:0]   exp;
        logic [POSIT_BITS-1:0] frac;
    } posit_unpacked_t;

    function automatic logic [POSIT_BITS-1:0] posit_zero();
        return '0;
    endfunction

    function automatic logic [POSIT_BITS-1:0] posit_nar();
        return {1'b1, {(POSIT_BITS-1){1'b0}}};
    endfunction

endpackage

// File: rtl/posit_rr_pick.sv
// Round-robin picker: pointer register plus rotated priority search, giving a
// one-hot grant and the winner index; the pointer advances past each winner.
module posit_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned TAGW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [TAGW-1:0] winner,
    output logic            found
);

    logic [TAGW-1:0] ptr;
    logic [TAGW-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = TAGW'((32'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        if (found) grant[winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (found)
            ptr <= (winner == TAGW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end

endmodule

// File: rtl/posit_unpack_arb.sv
// Round-robin shared posit unpacker with a single-entry valid/ready output stage.
// Optional per-requester accept counters: define POSIT_UNPACK_ARB_STATS_EN.
module posit_unpack_arb
    import posit_pkg::*;
#(
    parameter int unsigned BITS = POSIT_BITS,
    parameter int unsigned ES   = POSIT_ES,
    parameter int unsigned NREQ = 4,
    parameter int unsigned TAGW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*BITS-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TAGW-1:0]      out_tag,
    output logic                 out_sign,
    output logic                 out_zero,
    output logic                 out_nar,
    output logic [BITS-1:0]      out_seed,
    output logic [ES-1:0]        out_exp,
    output logic [BITS-1:0]      out_frac
`ifdef POSIT_UNPACK_ARB_STATS_EN
    ,
    input  logic [TAGW-1:0]      stat_sel,
    output logic [15:0]          stat_cnt
`endif
);

    localparam int unsigned RW = $clog2(BITS) + 1;

    if (BITS != POSIT_BITS || ES != POSIT_ES || NREQ < 2 || TAGW != $clog2(NREQ)) begin : g_bad_cfg
        $error("posit_unpack_arb: unsupported parameter set");
    end

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state;
    posit_unpacked_t res_q, nxt;
    logic [TAGW-1:0] tag_q, winner;
    logic [NREQ-1:0] grant;
    logic            can_accept, accept;
    logic [BITS-1:0] w, v, tmp;
    logic            r0, done;
    logic [RW-1:0]   run, sh;

    assign can_accept = (state == EMPTY) || out_ready;

    posit_rr_pick #(
        .NREQ (NREQ),
        .TAGW (TAGW)
    ) u_pick (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid & {NREQ{can_accept}}),
        .grant  (grant),
        .winner (winner),
        .found  (accept)
    );

    assign req_ready = grant;

    always_comb begin
        w = '0;
        for (int unsigned i = 0; i < NREQ; i++)
            if (winner == TAGW'(i)) w = req_data[i*BITS +: BITS];
    end

    // Shifting past the regime terminator leaves exponent then fraction
    // MSB-aligned, so short exponents come out zero-padded for free.
    always_comb begin
        nxt      = '0;
        v        = '0;
        tmp      = '0;
        r0       = 1'b0;
        done     = 1'b0;
        run      = '0;
        sh       = '0;
        nxt.sign = w[BITS-1];
        if (w == posit_zero()) begin
            nxt.zero = 1'b1;
        end else if (w == posit_nar()) begin
            nxt.nar = 1'b1;
        end else begin
            v  = w[BITS-1] ? (~w + BITS'(1)) : w;
            r0 = v[BITS-2];
            for (int unsigned i = 0; i < BITS - 1; i++) begin
                if (!done && v[BITS-2-i] == r0) run = run + RW'(1);
                else done = 1'b1;
            end
            sh       = run + RW'(2);
            tmp      = v << sh;
            nxt.seed = r0 ? (BITS'(run) - BITS'(1)) : (~BITS'(run) + BITS'(1));
            nxt.exp  = tmp[BITS-1 -: ES];
            nxt.frac = tmp << ES;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            res_q <= '0;
            tag_q <= '0;
        end else if (accept) begin
            state <= FULL;
            res_q <= nxt;
            tag_q <= winner;
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end

    assign out_valid = (state == FULL);
    assign out_tag   = tag_q;
    assign out_sign  = res_q.sign;
    assign out_zero  = res_q.zero;
    assign out_nar   = res_q.nar;
    assign out_seed  = res_q.seed;
    assign out_exp   = res_q.exp;
    assign out_frac  = res_q.frac;

`ifdef POSIT_UNPACK_ARB_STATS_EN
    logic [15:0] acc_cnt [NREQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREQ; i++) acc_cnt[i] <= '0;
        end else if (accept && acc_cnt[winner] != '1) begin
            acc_cnt[winner] <= acc_cnt[winner] + 16'd1;
        end
    end

    assign stat_cnt = acc_cnt[stat_sel];
`endif

endmodule

// File: tb/tb_posit_unpack_arb.sv
// Self-checking bench for posit_unpack_arb: decode vector table, directed
// fairness/back-pressure/reset sequences, then randomized traffic vs a reference model.
module tb_posit_unpack_arb;

    typedef struct packed {
        logic        sign;
        logic        zero;
        logic        nar;
        logic [31:0] seed;
        logic [2:0]  exp;
        logic [31:0] frac;
    } res_t;

    typedef struct {
        int          idx;
        logic [31:0] w;
        res_t        e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   out_tag;
    logic         out_sign, out_zero, out_nar;
    logic [31:0]  out_seed, out_frac;
    logic [2:0]   out_exp;

    int errors = 0;
    int checks = 0;

    bit   m_full = 1'b0;
    int   m_ptr  = 0;
    int   m_tag  = 0;
    res_t m_res  = '0;

    vec_t tbl[12];

    always #5 clk = ~clk;

    posit_unpack_arb #(
        .BITS (32),
        .ES   (3),
        .NREQ (4),
        .TAGW (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .out_sign  (out_sign),
        .out_zero  (out_zero),
        .out_nar   (out_nar),
        .out_seed  (out_seed),
        .out_exp   (out_exp),
        .out_frac  (out_frac)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    // Posit decode from the run-length definition, using leading-zero arithmetic.
    function automatic res_t ref_unpack(input logic [31:0] w);
        res_t            r;
        longint unsigned m, x, y, rest;
        int              k;
        r      = '0;
        r.sign = w[31];
        if (w == 32'h0) begin
            r.zero = 1'b1;
            return r;
        end
        if (w == 32'h8000_0000) begin
            r.nar = 1'b1;
            return r;
        end
        m      = w[31] ? ((64'h1_0000_0000 - 64'(w)) & 64'hFFFF_FFFF) : 64'(w);
        x      = (m << 1) & 64'hFFFF_FFFF;
        y      = x[31] ? (~x & 64'hFFFF_FFFF) : x;
        k      = 32 - $clog2(y + 1);
        r.seed = x[31] ? 32'(k - 1) : 32'(-k);
        rest   = (m << (k + 2)) & 64'hFFFF_FFFF;
        r.exp  = rest[31:29];
        r.frac = 32'(rest << 3);
        return r;
    endfunction

    function automatic vec_t mk(input int idx, input logic [31:0] w, input logic s, input logic z,
                                input logic n, input logic [31:0] seed, input logic [2:0] e,
                                input logic [31:0] f);
        vec_t v;
        v.idx = idx;
        v.w   = w;
        v.e   = {s, z, n, seed, e, f};
        return v;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // One clock: compare grant and held result with the model at negedge, then advance the model.
    task automatic cycle();
        int       win;
        bit       can;
        logic [3:0] want_rdy;
        @(negedge clk);
        can = !m_full || out_ready;
        win = -1;
        if (can) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (win < 0 && req_valid[j]) win = j;
            end
        end
        want_rdy = (win >= 0) ? (4'b0001 << win) : 4'b0000;
        chk("req_ready", req_ready, want_rdy);
        chk("out_valid", out_valid, m_full);
        if (m_full) begin
            chk("out_tag", out_tag, m_tag);
            chk("out_sign", out_sign, m_res.sign);
            chk("out_zero", out_zero, m_res.zero);
            chk("out_nar", out_nar, m_res.nar);
            chk("out_seed", out_seed, m_res.seed);
            chk("out_exp", out_exp, m_res.exp);
            chk("out_frac", out_frac, m_res.frac);
        end
        if (win >= 0) begin
            m_res  = ref_unpack(req_data[win*32 +: 32]);
            m_tag  = win;
            m_full = 1'b1;
            m_ptr  = (win + 1) % 4;
        end else if (out_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_full = 1'b0;
        m_ptr  = 0;
    endtask

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_flags", {out_sign, out_zero, out_nar}, 0);
        chk("rst_out_seed", out_seed, 0);
        chk("rst_out_exp", out_exp, 0);
        chk("rst_out_frac", out_frac, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        tbl[0]  = mk(0, 32'h4000_0000, 0, 0, 0, 32'h0000_0000, 3'd0, 32'h0000_0000);
        tbl[1]  = mk(2, 32'h4800_0000, 0, 0, 0, 32'h0000_0000, 3'd2, 32'h0000_0000);
        tbl[2]  = mk(1, 32'h2000_0000, 0, 0, 0, 32'hFFFF_FFFF, 3'd0, 32'h0000_0000);
        tbl[3]  = mk(3, 32'hC000_0000, 1, 0, 0, 32'h0000_0000, 3'd0, 32'h0000_0000);
        tbl[4]  = mk(0, 32'h0000_0000, 0, 1, 0, 32'h0000_0000, 3'd0, 32'h0000_0000);
        tbl[5]  = mk(1, 32'h8000_0000, 1, 0, 1, 32'h0000_0000, 3'd0, 32'h0000_0000);
        tbl[6]  = mk(2, 32'h7FFF_FFFF, 0, 0, 0, 32'd30,        3'd0, 32'h0000_0000);
        tbl[7]  = mk(3, 32'h0000_0001, 0, 0, 0, 32'hFFFF_FFE2, 3'd0, 32'h0000_0000);
        tbl[8]  = mk(0, 32'h5A5A_5A5A, 0, 0, 0, 32'h0000_0000, 3'd6, 32'h9696_9680);
        tbl[9]  = mk(1, 32'hFFFF_FFFF, 1, 0, 0, 32'hFFFF_FFE2, 3'd0, 32'h0000_0000);
        tbl[10] = mk(2, 32'h7FFF_FFFD, 0, 0, 0, 32'd28,        3'd4, 32'h0000_0000);
        tbl[11] = mk(3, 32'h0000_0003, 0, 0, 0, 32'hFFFF_FFE3, 3'd4, 32'h0000_0000);

        out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            req_data = '0;
            req_data[tbl[t].idx*32 +: 32] = tbl[t].w;
            req_valid = 4'b0001 << tbl[t].idx;
            cycle();
            req_valid = '0;
            chk("vec_valid", out_valid, 1);
            chk("vec_tag", out_tag, tbl[t].idx);
            chk("vec_sign", out_sign, tbl[t].e.sign);
            chk("vec_zero", out_zero, tbl[t].e.zero);
            chk("vec_nar", out_nar, tbl[t].e.nar);
            chk("vec_seed", out_seed, tbl[t].e.seed);
            chk("vec_exp", out_exp, tbl[t].e.exp);
            chk("vec_frac", out_frac, tbl[t].e.frac);
            cycle();
        end

        // Fairness with all requesters held valid: 0,1,2,3,0 with no bubbles.
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h4000_0000 + (i << 20);
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fair_grant", req_ready, 4'b0001 << (i % 4));
            if (i > 0) chk("fair_valid", out_valid, 1);
            cycle();
        end

        // Back-pressure: no grants and a stable held result.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", req_ready, 0);
            chk("bp_tag", out_tag, 0);
            chk("bp_seed", out_seed, 0);
            cycle();
        end

        // Asynchronous reset while holding; pointer returns to requester 0.
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", out_valid, 0);
        m_full = 1'b0;
        m_ptr  = 0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("rst_first_grant", req_ready, 4'b0001);
        cycle();

        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = rand_word();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/posit_unpack_arb.md
Name: posit_unpack_arb

Overview:
- Shares one combinational posit unpacker between NREQ requesters with a round-robin arbiter.
- Handles sign and special values (zero, NaR) around the unpacker.
- Registers the result in a single-entry output stage with a valid/ready handshake and a requester tag.
- Sits between the operand-fetch ports of the posit ALU lanes and the decoded-operand datapath.

Parameters:
- BITS, 32, posit word width.
- ES, 3, exponent field width.
- NREQ, 4, number of requesters (≥2).
- TAGW, 2, tag width; must equal clog2(NREQ).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  NREQ*BITS  packed operands; requester i occupies bits [i*BITS +: BITS].
- req_ready  out  NREQ  one-hot grant/accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_tag  out  TAGW  index of the requester that produced the result.
- out_sign  out  1  sign bit of the original word.
- out_zero  out  1  word was all zeros.
- out_nar  out  1  word was NaR (1 followed by BITS-1 zeros).
- out_seed  out  BITS  signed regime value.
- out_exp  out  ES  exponent, zero-padded on the right when truncated.
- out_frac  out  BITS  fraction, MSB-aligned, hidden bit excluded.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0; out_tag, out_sign, out_zero, out_nar, out_seed, out_exp, out_frac all 0.
  - Round-robin pointer=0, so requester 0 has highest priority.
- States:
  - EMPTY (out_valid=0) and FULL (out_valid=1).
  - can_accept = EMPTY | (FULL & out_ready).
- Arbitration:
  - When can_accept, the winner is the first asserted req_valid searching from the pointer upward, with wrap-around.
  - req_ready is one-hot at the winner and 0 elsewhere. When !can_accept or no req_valid, req_ready is all zeros.
  - req_ready depends combinationally on req_valid and out_ready. Requesters must not make req_valid depend on req_ready.
- Accept:
  - An accept is the winner's req_valid & req_ready.
  - On accept, the pointer moves to (winner+1) mod NREQ. With no accept, the pointer holds.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY when out_ready and no accept.
  - FULL→FULL when out_ready and accept (back-to-back, one result per cycle), or when !out_ready (all outputs held stable).
- Latency: result is valid 1 cycle after accept. Throughput is 1 result per cycle.
- Datapath (combinational, before the output register):
  - w = winner's word; out_sign = w[BITS-1].
  - If w==0: zero=1; seed, exp, frac = 0.
  - If w==1<<(BITS-1): nar=1; seed, exp, frac = 0.
  - Otherwise the unpacker receives the two's complement of w when the sign is 1, else w.
- Unpacker regime/exp/frac rules:
  - The regime run starts at bit BITS-2.
  - A run of k ones gives seed=k-1; a run of k zeros gives seed=-k.
  - The terminating bit is skipped.
  - Up to ES exponent bits follow; if fewer remain, they are left-aligned and zero-padded.
  - Remaining bits are MSB-aligned into frac.
- Reset mid-operation: any held result is discarded (out_valid drops asynchronously). No partial accept survives reset.

Optional Feature:
- Macro: POSIT_UNPACK_ARB_STATS_EN.
- Defined:
  - Adds NREQ 16-bit saturating accept counters, cleared by rst, each incremented on its requester's accept and holding at 0xFFFF.
  - Adds ports stat_sel (in, TAGW) and stat_cnt (out, 16); stat_cnt is the counter selected by stat_sel, combinationally.
- Undefined: no counters and no stat ports; the rest of the behaviour is identical.

Decomposition:
- Shared package posit_pkg:
  - BITS/ES defaults.
  - NaR and zero constant functions.
  - Struct type for the unpacked result {sign, zero, nar, seed, exp, frac}.
- One natural sub-module, posit_rr_pick: pointer register plus rotate/priority-encode, producing the one-hot grant and winner index.
- The shared unpacker is instantiated once, combinationally, inside this block.

Test Plan:
- Single requester: req 0 sends 0x40000000 → next cycle out_valid=1, tag=0, sign=0, seed=0, exp=0, frac=0.
- Exponent field: req 2 sends 0x48000000 → exp=3'b010, seed=0, frac=0, tag=2.
- Negative regime and sign: 0x20000000 → seed=-1, exp=0; 0xC0000000 → sign=1, seed=0, exp=0, frac=0.
- Specials: 0x00000000 → zero=1, nar=0; 0x80000000 → nar=1, zero=0; seed/exp/frac=0 in both.
- Fairness and back-to-back: all four req_valid held with out_ready=1 → accepts 0,1,2,3,0 on consecutive cycles, no bubbles.
- Back-pressure and reset:
  - out_ready=0 while FULL → req_ready=0 and outputs stable for 5 cycles.
  - Assert rst mid-hold → out_valid=0 immediately; after release with all requesters valid, first grant goes to requester 0.
